// File: rtl/grid_erode_pkg.sv
// Shared types and constants for the grid erosion engine.
// The states, the ASCII codes and the 8-neighbour count helper live here.
package grid_erode_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME0,
        S_PRIME1,
        S_SCAN,
        S_PASS_END,
        S_DONE
    } state_t;

    localparam logic [7:0] CH_OCC   = 8'h40;  // '@'
    localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL    = 8'h0A;  // '\n'

    localparam int RES_W  = 64;
    localparam int PASS_W = 16;

    function automatic logic [3:0] nb_count(input logic [7:0] b);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'd0, b[i]};
        return s;
    endfunction

endpackage

// File: rtl/grid_erode_core_row_threshold_logic.sv
// Combinational removal mask for one row from a 3-row window.
// A cell is removed when it is occupied, it lies inside the grid, and it has fewer than thr occupied neighbours.
module row_threshold_logic
    import grid_erode_pkg::*;
#(
    parameter int MAX_COLS = 256,
    parameter int COL_BITS = 9
) (
    input  logic [MAX_COLS-1:0] prev,
    input  logic [MAX_COLS-1:0] curr,
    input  logic [MAX_COLS-1:0] next,
    input  logic [3:0]          thr,
    input  logic [COL_BITS-1:0] n_cols,
    output logic [MAX_COLS-1:0] mask
);

    logic [MAX_COLS-1:0] col_ok;
    logic [MAX_COLS+1:0] p_ext;
    logic [MAX_COLS+1:0] c_ext;
    logic [MAX_COLS+1:0] n_ext;

    // Columns past n_cols are outside the grid, so they are treated as empty neighbours too.
    assign p_ext = {1'b0, prev & col_ok, 1'b0};
    assign c_ext = {1'b0, curr & col_ok, 1'b0};
    assign n_ext = {1'b0, next & col_ok, 1'b0};

    for (genvar i = 0; i < MAX_COLS; i++) begin : g_col
        logic [3:0] cnt;
        assign col_ok[i] = (COL_BITS'(i) < n_cols);
        assign cnt = nb_count({p_ext[i], p_ext[i+1], p_ext[i+2],
                               c_ext[i],             c_ext[i+2],
                               n_ext[i], n_ext[i+1], n_ext[i+2]});
        assign mask[i] = c_ext[i+1] & (cnt < thr);
    end

endmodule

// File: rtl/grid_erode_core.sv
// Grid erosion engine: loads an '@'/'.' grid from a ROM, then repeatedly removes sparse cells.
// Each pass scans one row per clock and counts removals; results are held while done is high.
module grid_erode_core
    import grid_erode_pkg::*;
#(
    parameter int MAX_ROWS    = 256,
    parameter int MAX_COLS    = 256,
    parameter int ROW_BITS    = 8,
    parameter int COL_BITS    = 9,
    parameter int N_ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             thr,
    input  logic [PASS_W-1:0]      max_passes,
    input  logic [7:0]             rom_data,
    input  logic                   rom_valid,
    output logic [N_ADDR_BITS:0]   rom_addr,
    output logic                   busy,
    output logic                   done,
    output logic [RES_W-1:0]       part1_result,
    output logic [RES_W-1:0]       part2_result,
    output logic [PASS_W-1:0]      pass_count
);

    localparam int RB  = ROW_BITS + 1;  // row counts must reach MAX_ROWS itself
    localparam int CIW = $clog2(MAX_COLS);

    state_t                state;
    logic [3:0]            thr_q;
    logic [PASS_W-1:0]     max_q;
    logic [MAX_COLS-1:0]   line_buf, prev_r, curr_r, next_r, mask, rd_data, rd_use, wd;
    logic [COL_BITS-1:0]   col, n_cols, removed;
    logic [RB-1:0]         row, n_rows, k, ra_full, rd_row, rows_final;
    logic [ROW_BITS-1:0]   wa, ra;
    logic                  n_cols_set, we;
    logic [RES_W-1:0]      pass_cnt;
    logic [MAX_COLS-1:0]   mem [0:MAX_ROWS-1];

    row_threshold_logic #(.MAX_COLS(MAX_COLS), .COL_BITS(COL_BITS)) u_thr (
        .prev   (prev_r),
        .curr   (curr_r),
        .next   (next_r),
        .thr    (thr_q),
        .n_cols (n_cols),
        .mask   (mask)
    );

    // Read runs one row ahead of the row entering the window; the pass-end and EOF cycles fetch row 0.
    always_comb begin
        we      = 1'b0;
        wa      = row[ROW_BITS-1:0];
        wd      = line_buf;
        ra_full = '0;
        rd_row  = '0;
        case (state)
            S_LOAD: we = ((rom_valid && rom_data == CH_NL) || (!rom_valid && col != '0))
                         && (row < RB'(MAX_ROWS));
            S_PRIME0: ra_full = RB'(1);
            S_PRIME1: begin
                ra_full = RB'(2);
                rd_row  = RB'(1);
            end
            S_SCAN: begin
                we      = 1'b1;
                wa      = k[ROW_BITS-1:0];
                wd      = curr_r & ~mask;
                ra_full = k + RB'(3);
                rd_row  = k + RB'(2);
            end
            default: ;
        endcase
    end

    assign ra         = ra_full[ROW_BITS-1:0];
    assign rd_use     = (rd_row < n_rows) ? rd_data : '0;
    assign rows_final = row + {{(RB-1){1'b0}}, (col != '0 && row < RB'(MAX_ROWS))};

    always_comb begin
        removed = '0;
        for (int i = 0; i < MAX_COLS; i++) removed = removed + {{(COL_BITS-1){1'b0}}, mask[i]};
    end

    // Bypass covers the EOF flush of a lone first row racing the row-0 prefetch.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_data <= (we && wa == ra) ? wd : mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rom_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            part1_result <= '0;
            part2_result <= '0;
            pass_count   <= '0;
            thr_q        <= '0;
            max_q        <= '0;
            line_buf     <= '0;
            prev_r       <= '0;
            curr_r       <= '0;
            next_r       <= '0;
            col          <= '0;
            row          <= '0;
            n_rows       <= '0;
            n_cols       <= '0;
            n_cols_set   <= 1'b0;
            k            <= '0;
            pass_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr     <= '0;
                        part1_result <= '0;
                        part2_result <= '0;
                        pass_count   <= '0;
                        pass_cnt     <= '0;
                        line_buf     <= '0;
                        col          <= '0;
                        row          <= '0;
                        n_rows       <= '0;
                        n_cols       <= '0;
                        n_cols_set   <= 1'b0;
                        thr_q        <= thr;
                        max_q        <= max_passes;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rom_valid) begin
                        rom_addr <= rom_addr + 1'b1;
                        if (rom_data == CH_OCC || rom_data == CH_EMPTY) begin
                            if (col < COL_BITS'(MAX_COLS)) begin
                                line_buf[col[CIW-1:0]] <= (rom_data == CH_OCC);
                                col <= col + 1'b1;
                            end
                        end else if (rom_data == CH_NL) begin
                            if (!n_cols_set) begin
                                n_cols     <= col;
                                n_cols_set <= 1'b1;
                            end
                            line_buf <= '0;
                            col      <= '0;
                            if (row < RB'(MAX_ROWS)) row <= row + 1'b1;
                        end
                    end else begin
                        if (col != '0 && !n_cols_set) begin
                            n_cols     <= col;
                            n_cols_set <= 1'b1;
                        end
                        n_rows <= rows_final;
                        if (rows_final == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_PRIME0;
                        end
                    end
                end
                S_PRIME0: begin
                    prev_r <= '0;
                    curr_r <= '0;
                    next_r <= rd_use;
                    k      <= '0;
                    state  <= S_PRIME1;
                end
                S_PRIME1: begin
                    prev_r <= curr_r;
                    curr_r <= next_r;
                    next_r <= rd_use;
                    state  <= S_SCAN;
                end
                S_SCAN: begin
                    prev_r   <= curr_r;
                    curr_r   <= next_r;
                    next_r   <= rd_use;
                    pass_cnt <= pass_cnt + RES_W'(removed);
                    k        <= k + 1'b1;
                    if (k == n_rows - RB'(1)) state <= S_PASS_END;
                end
                S_PASS_END: begin
                    pass_count   <= pass_count + 1'b1;
                    part2_result <= part2_result + pass_cnt;
                    if (pass_count == '0) part1_result <= pass_cnt;
                    if (pass_cnt == '0 || (max_q != '0 && pass_count + 1'b1 == max_q)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pass_cnt <= '0;
                        state    <= S_PRIME0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_erode_core.sv
// Self-checking bench for grid_erode_core: fixed grids with known results, random grids against a
// reference erosion model, handshake corner cases and an asynchronous reset during a scan.
module tb_grid_erode_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  thr = '0;
    logic [15:0] max_passes = '0;
    logic [7:0]  rom_data;
    logic        rom_valid;
    logic [16:0] rom_addr;
    logic        busy, done;
    logic [63:0] part1_result, part2_result;
    logic [15:0] pass_count;

    grid_erode_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .thr          (thr),
        .max_passes   (max_passes),
        .rom_data     (rom_data),
        .rom_valid    (rom_valid),
        .rom_addr     (rom_addr),
        .busy         (busy),
        .done         (done),
        .part1_result (part1_result),
        .part2_result (part2_result),
        .pass_count   (pass_count)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:32767];
    int         rom_len = 0;

    always_comb begin
        rom_valid = (int'(rom_addr) < rom_len);
        rom_data  = rom_valid ? rom_mem[rom_addr[14:0]] : 8'h00;
    end

    bit g  [0:136][0:136];
    bit mg [0:136][0:136];
    bit rm [0:136][0:136];
    int g_rows, g_cols;
    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic fill_grid(input int rows, input int cols, input int pct);
        g_rows = rows;
        g_cols = cols;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                g[r][c] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic build_rom(input bit trailing_nl, input bit crlf);
        rom_len = 0;
        for (int r = 0; r < g_rows; r++) begin
            for (int c = 0; c < g_cols; c++) begin
                rom_mem[rom_len] = g[r][c] ? 8'h40 : 8'h2E;
                rom_len++;
            end
            if (r < g_rows - 1 || trailing_nl) begin
                if (crlf) begin
                    rom_mem[rom_len] = 8'h0D;
                    rom_len++;
                end
                rom_mem[rom_len] = 8'h0A;
                rom_len++;
            end
        end
    endtask

    task automatic model_run(input int thr_v, input int maxp,
                             output logic [63:0] p1, output logic [63:0] p2, output logic [63:0] pc);
        int  cnt, nb;
        bit  stop;
        p1 = 0; p2 = 0; pc = 0;
        stop = (g_rows == 0);
        for (int r = 0; r < g_rows; r++)
            for (int c = 0; c < g_cols; c++)
                mg[r][c] = g[r][c];
        while (!stop) begin
            cnt = 0;
            for (int r = 0; r < g_rows; r++) begin
                for (int c = 0; c < g_cols; c++) begin
                    rm[r][c] = 1'b0;
                    if (mg[r][c]) begin
                        nb = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < g_rows &&
                                    c + dc >= 0 && c + dc < g_cols && mg[r+dr][c+dc])
                                    nb++;
                        if (nb < thr_v) begin
                            rm[r][c] = 1'b1;
                            cnt++;
                        end
                    end
                end
            end
            for (int r = 0; r < g_rows; r++)
                for (int c = 0; c < g_cols; c++)
                    if (rm[r][c]) mg[r][c] = 1'b0;
            pc++;
            if (pc == 1) p1 = 64'(cnt);
            p2 = p2 + 64'(cnt);
            if (cnt == 0 || (maxp != 0 && pc == 64'(maxp))) stop = 1'b1;
        end
    endtask

    task automatic push_expected(input logic [63:0] p1, input logic [63:0] p2, input logic [63:0] pc);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_q.push_back(pc);
    endtask

    task automatic do_start(input int thr_v, input int maxp);
        @(negedge clk);
        start      = 1'b1;
        thr        = 4'(thr_v);
        max_passes = 16'(maxp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rom_addr, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: addr=%0d busy=%0b done=%0b, required all 0", rom_addr, busy, done);
        end
        tests_run++;
        if ({part1_result, part2_result, pass_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_results: p1=%0d p2=%0d pc=%0d, required 0", part1_result, part2_result, pass_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full3_unbounded();
        int cyc;
        logic [63:0] e;
        fill_grid(3, 3, 100);
        build_rom(1'b1, 1'b0);
        push_expected(64'd4, 64'd9, 64'd4);
        do_start(4, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL full3_busy: busy=%0b, required 1", busy);
        end
        wait_done(500, cyc);
        tests_run++;
        if (cyc !== 37) begin
            tests_failed++;
            $display("FAIL full3_latency: got %0d cycles, required 37", cyc);
        end
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL full3_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL full3_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL full3_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_single_no_nl();
        int cyc;
        logic [63:0] e;
        fill_grid(1, 1, 100);
        build_rom(1'b0, 1'b0);
        push_expected(64'd1, 64'd1, 64'd2);
        do_start(4, 0);
        wait_done(200, cyc);
        tests_run++;
        if (cyc !== 10) begin tests_failed++; $display("FAIL single_latency: got %0d cycles, required 10", cyc); end
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL single_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL single_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL single_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_empty_rom();
        int cyc;
        logic [63:0] e;
        g_rows = 0; g_cols = 0;
        rom_len = 0;
        push_expected(64'd0, 64'd0, 64'd0);
        do_start(4, 0);
        wait_done(50, cyc);
        tests_run++;
        if (cyc > 3) begin tests_failed++; $display("FAIL empty_latency: got %0d cycles, required <= 3", cyc); end
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL empty_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL empty_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL empty_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_thr_zero();
        int cyc;
        logic [63:0] e;
        fill_grid(3, 3, 100);
        build_rom(1'b1, 1'b0);
        push_expected(64'd0, 64'd0, 64'd1);
        do_start(0, 0);
        wait_done(500, cyc);
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL thr0_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL thr0_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL thr0_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_max_passes_one();
        int cyc;
        logic [63:0] e;
        fill_grid(3, 3, 100);
        build_rom(1'b1, 1'b0);
        push_expected(64'd4, 64'd4, 64'd1);
        do_start(4, 1);
        wait_done(500, cyc);
        // 12 ROM bytes + EOF cycle + one pass of n_rows+3 cycles
        tests_run++;
        if (cyc !== 19) begin tests_failed++; $display("FAIL maxp1_latency: got %0d cycles, required 19", cyc); end
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL maxp1_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL maxp1_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL maxp1_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_random_grids();
        int cfg [6][6] = '{'{6, 11, 3, 0, 1, 0}, '{2, 5, 4, 0, 0, 1}, '{7, 4, 9, 0, 1, 0},
                           '{5, 9, 5, 2, 1, 1}, '{4, 13, 1, 0, 0, 0}, '{3, 1, 2, 0, 1, 0}};
        int cyc;
        logic [63:0] p1, p2, pc, e;
        for (int t = 0; t < 6; t++) begin
            fill_grid(cfg[t][0], cfg[t][1], 65);
            build_rom(cfg[t][4] != 0, cfg[t][5] != 0);
            model_run(cfg[t][2], cfg[t][3], p1, p2, pc);
            push_expected(p1, p2, pc);
            do_start(cfg[t][2], cfg[t][3]);
            wait_done(3000, cyc);
            e = exp_q.pop_front(); tests_run++;
            if (part1_result !== e) begin tests_failed++; $display("FAIL rand%0d_part1: got %0d required %0d", t, part1_result, e); end
            e = exp_q.pop_front(); tests_run++;
            if (part2_result !== e) begin tests_failed++; $display("FAIL rand%0d_part2: got %0d required %0d", t, part2_result, e); end
            e = exp_q.pop_front(); tests_run++;
            if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL rand%0d_passes: got %0d required %0d", t, pass_count, e); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] e;
        fill_grid(3, 3, 100);
        build_rom(1'b1, 1'b0);
        push_expected(64'd4, 64'd9, 64'd4);
        do_start(4, 0);
        repeat (5) @(negedge clk);
        do_start(0, 1);  // must be ignored while busy
        wait_done(500, cyc);
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL b2b_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL b2b_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL b2b_passes: got %0d required %0d", pass_count, e); end
        push_expected(64'd9, 64'd9, 64'd2);
        do_start(9, 0);
        tests_run++;
        if ({busy, done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL restart_flags: busy=%0b done=%0b, required busy=1 done=0", busy, done);
        end
        wait_done(500, cyc);
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL restart_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL restart_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL restart_passes: got %0d required %0d", pass_count, e); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        logic [63:0] p1, p2, pc, e;
        fill_grid(137, 137, 65);
        build_rom(1'b1, 1'b0);
        model_run(4, 0, p1, p2, pc);
        do_start(4, 0);
        // load is rom_len+1 cycles, then two prime cycles, then land well inside the scan
        repeat (rom_len + 1 + 2 + 60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rom_addr, busy, done, part1_result, part2_result, pass_count} !== '0) begin
            tests_failed++;
            $display("FAIL midscan_reset: addr=%0d busy=%0b done=%0b p1=%0d p2=%0d pc=%0d, required all 0",
                     rom_addr, busy, done, part1_result, part2_result, pass_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_expected(p1, p2, pc);
        do_start(4, 0);
        wait_done(60000, cyc);
        e = exp_q.pop_front(); tests_run++;
        if (part1_result !== e) begin tests_failed++; $display("FAIL big_part1: got %0d required %0d", part1_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if (part2_result !== e) begin tests_failed++; $display("FAIL big_part2: got %0d required %0d", part2_result, e); end
        e = exp_q.pop_front(); tests_run++;
        if ({48'd0, pass_count} !== e) begin tests_failed++; $display("FAIL big_passes: got %0d required %0d", pass_count, e); end
    endtask

    initial begin
        test_reset();
        test_full3_unbounded();
        test_single_no_nl();
        test_empty_rom();
        test_thr_zero();
        test_max_passes_one();
        test_random_grids();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
